pattern_count_engine: RTL and testbench
=======================================

# pattern_count_engine

Hardware implementation of the program-3 pattern counter. It sits beside the data memory as a start/ack responder to a host or test bench. On `start` it reads the 32-byte message at addresses 0–31 and the pattern byte at address 32. It then writes three 8-bit counts to addresses 33–35 and pulses `ack`, using the same address map and handshake a software program-3 run uses.

## Interface
- `MSG_BYTES`, default 32: message length in bytes.
- `ADDR_W`, default 8: data-memory address width.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `ack`  out  1  one-cycle done pulse.
- `mem_addr`  out  ADDR_W  data-memory address.
- `mem_rd_data`  in  8  combinational read data for `mem_addr`, same cycle.
- `mem_wr_en`  out  1  write strobe, committed at the next `clk` edge.
- `mem_wr_data`  out  8  write data.

## Operation
- Pattern P is `mem[32][7:3]`. Bits [2:0] of `mem[32]` are ignored.
- The message string S is 256 bits, `mem[0]` first (MSB), bit 7 of each byte first.
- Count results:
  - `mem[33]` = ctb, the number of in-byte windows equal to P: `b[7:3]`, `b[6:2]`, `b[5:1]`, `b[4:0]` summed over all bytes. Max 128.
  - `mem[34]` = cto, the number of bytes with at least one in-byte match. Max 32.
  - `mem[35]` = cts, the number of matches over all 252 5-bit windows of S. It equals ctb plus the crossing windows of every adjacent pair (b_i, b_i+1): `{b_i[3:0],b_i+1[7]}`, `{b_i[2:0],b_i+1[7:6]}`, `{b_i[1:0],b_i+1[7:5]}`, `{b_i[0],b_i+1[7:4]}`, for i = 0..30. Max 252.
- All counters are 8 bits. No saturation is needed, since the maxima fit.
- State machine:
  - IDLE: if `start`, go to LOAD_PAT and clear all counters and the byte index.
  - LOAD_PAT: `mem_addr`=32; register P.
  - SCAN: `mem_addr`=index, running 0..MSG_BYTES-1. Each cycle, accumulate in-byte matches and the cto flag. If index > 0, also add crossing matches using the registered previous byte. Register the current byte as the previous byte. After the last index, go to WR_CTB.
  - WR_CTB / WR_CTO / WR_CTS: `mem_wr_en`=1 at address 33 / 34 / 35 with the respective count, then advance to the next state.
  - DONE: `ack`=1, go to IDLE.
- `start` outside IDLE is ignored. If `start` is still high in the IDLE cycle after DONE, a new run begins.
- `reset`, including mid-run, forces IDLE with counters and registers cleared. Writes not yet committed never occur.

## Timing
- Reset values: `ack`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0. All outputs are registered or decoded from state, with zero values in IDLE.
- Take `start` sampled high in IDLE at cycle t:
  - LOAD_PAT at t+1.
  - SCAN at t+2..t+33.
  - Writes at t+34, t+35, t+36.
  - `ack` high exactly at cycle t+37.
  - IDLE at t+38.
- `ack` is a single-cycle pulse. Results are committed to memory no later than the edge ending t+36, so they are visible when `ack` is seen.
- There is no other memory access during a run; the host must not write memory between `start` and `ack`.

## Structure
- Package `pattern_pkg`:
  - `MSG_BASE`=0, `PAT_ADDR`=32, `CTB_ADDR`=33, `CTO_ADDR`=34, `CTS_ADDR`=35.
  - State enum `pc_state_t` {IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE}.
- Sub-module `pattern_match_unit` (combinational).
  - Inputs: P, current byte, previous byte, `first` flag.
  - Outputs: `in_cnt` (0–4), `any_in` (1 bit), `cross_cnt` (0–4, forced to 0 when `first`).
- `pattern_count_engine` holds the FSM, index counter, previous-byte register, accumulators and memory muxing.

## Test plan
- Message all 0x00, `mem[32]`=0x00 → `mem[33..35]` = 128, 32, 252; `ack` at t+37.
- Message all 0x55, `mem[32]`=0xA8 (P=10101) → 64, 32, 126.
- Message all 0x00, `mem[32]`=0xF8 (P=11111) → 0, 0, 0.
- Message zero except `mem[0]`=0x0F and `mem[1]`=0x80, `mem[32]`=0xF8 → 0, 0, 1 (crossing-only match).
- Random message and pattern (20 seeds) → the results match a bench reference model computing ctb/cto/cts as defined in Operation.
- Reset and busy handling:
  - Pulse `reset` at t+10 → no `ack` and `mem[33..35]` unchanged.
  - A second `start` pulsed during SCAN is ignored.
  - A fresh `start` then completes with correct results at +37 cycles.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared address map, FSM state type and small helpers for the pattern counter.
package pattern_pkg;

  localparam int MSG_BASE = 0;
  localparam int PAT_ADDR = 32;
  localparam int CTB_ADDR = 33;
  localparam int CTO_ADDR = 34;
  localparam int CTS_ADDR = 35;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PAT,
    SCAN,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    DONE
  } pc_state_t;

  // Number of set bits in a 4-bit hit vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/pattern_match_unit.sv
// Combinational matcher: compares the 5-bit pattern against the four in-byte
// windows of the current byte and the four windows straddling prev/cur bytes.
module pattern_match_unit
  import pattern_pkg::*;
(
  input  logic [4:0] pat,
  input  logic [7:0] cur_byte,
  input  logic [7:0] prev_byte,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic       any_in,
  output logic [2:0] cross_cnt
);

  logic [15:0] pair;
  logic [3:0]  in_hit;
  logic [3:0]  cross_hit;

  assign pair = {prev_byte, cur_byte};

  // Window gi of the byte is b[7-gi:3-gi]; crossing window gi of the pair
  // starts gi bits further right, beginning at prev_byte[3].
  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    assign in_hit[gi]    = (cur_byte[7-gi -: 5] == pat);
    assign cross_hit[gi] = (pair[11-gi -: 5] == pat);
  end

  // Reduce hit vectors; the first byte has no predecessor so no crossings.
  always_comb begin
    in_cnt    = popcount4(in_hit);
    any_in    = |in_hit;
    cross_cnt = first ? 3'd0 : popcount4(cross_hit);
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Start/ack engine: reads the message and pattern from data memory, counts
// pattern occurrences three ways, writes the counts back and pulses ack.
module pattern_count_engine
  import pattern_pkg::*;
#(
  parameter int MSG_BYTES = 32,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  pc_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       pat_q, pat_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       ctb_q, ctb_d;
  logic [7:0]       cto_q, cto_d;
  logic [7:0]       cts_q, cts_d;

  logic [2:0] in_cnt;
  logic       any_in;
  logic [2:0] cross_cnt;

  pattern_match_unit u_match (
    .pat       (pat_q),
    .cur_byte  (mem_rd_data),
    .prev_byte (prev_q),
    .first     (idx_q == '0),
    .in_cnt    (in_cnt),
    .any_in    (any_in),
    .cross_cnt (cross_cnt)
  );

  // State, index, pattern, previous byte and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      prev_q  <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      prev_q  <= prev_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  // Next-state logic and memory/handshake outputs decoded from state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    prev_d      = prev_q;
    ctb_d       = ctb_q;
    cto_d       = cto_q;
    cts_d       = cts_q;
    ack         = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_PAT;
          idx_d   = '0;
          ctb_d   = '0;
          cto_d   = '0;
          cts_d   = '0;
        end
      end
      LOAD_PAT: begin
        mem_addr = ADDR_W'(PAT_ADDR);
        pat_d    = mem_rd_data[7:3];
        state_d  = SCAN;
      end
      SCAN: begin
        mem_addr = ADDR_W'(MSG_BASE) + ADDR_W'(idx_q);
        ctb_d    = ctb_q + 8'(in_cnt);
        cto_d    = cto_q + 8'(any_in);
        cts_d    = cts_q + 8'(in_cnt) + 8'(cross_cnt);
        prev_d   = mem_rd_data;
        if (idx_q == LAST_IDX) begin
          state_d = WR_CTB;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WR_CTB: begin
        mem_addr    = ADDR_W'(CTB_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb_q;
        state_d     = WR_CTO;
      end
      WR_CTO: begin
        mem_addr    = ADDR_W'(CTO_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto_q;
        state_d     = WR_CTS;
      end
      WR_CTS: begin
        mem_addr    = ADDR_W'(CTS_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts_q;
        state_d     = DONE;
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed and random checks of pattern_count_engine against a bit-string model.
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_count_engine #(.MSG_BYTES(32), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  assign mem_rd_data = mem[mem_addr];

  // Memory: bulk host load from img, otherwise DUT writes.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load();
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Reference: treat the message as a 256-bit string and count windows directly.
  task automatic ref_counts(output int ctb, output int cto, output int cts);
    int p;
    logic s [256];
    p = int'(img[32]) >> 3;
    ctb = 0; cto = 0; cts = 0;
    for (int i = 0; i < 32; i++) begin
      int hits;
      hits = 0;
      for (int sh = 3; sh >= 0; sh--) begin
        if (((int'(img[i]) >> sh) & 31) == p) hits++;
      end
      ctb += hits;
      if (hits > 0) cto++;
    end
    for (int j = 0; j < 256; j++) s[j] = img[j / 8][7 - (j % 8)];
    for (int j = 0; j <= 251; j++) begin
      int w;
      w = 0;
      for (int m = 0; m < 5; m++) w = (w << 1) | int'(s[j + m]);
      if (w == p) cts++;
    end
  endtask

  // One run: start in cycle t, watch 60 cycles; optional reset / extra start.
  task automatic run(input string tag, input int rst_at, input int restart_at);
    int ack_cyc;
    int pulses;
    int ectb, ecto, ects;
    logic [7:0] old33, old34, old35;
    ref_counts(ectb, ecto, ects);
    old33 = mem[33]; old34 = mem[34]; old35 = mem[35];
    ack_cyc = -1;
    pulses  = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        pulses++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (rst_at == 0) begin
        if (c == 1)  check({tag, " pat_addr"}, int'(mem_addr), 32);
        if (c == 2)  check({tag, " scan_addr0"}, int'(mem_addr), 0);
        if (c == 34) check({tag, " wr_ctb"}, int'({mem_wr_en, mem_addr}), 256 + 33);
      end
      if (c == 1) start = 1'b0;
      if (c == restart_at) start = 1'b1;
      if (c == restart_at + 1) start = 1'b0;
      if (c == rst_at) reset = 1'b1;
      if (c == rst_at + 1) reset = 1'b0;
    end
    if (rst_at > 0) begin
      check({tag, " ack_pulses"}, pulses, 0);
      check({tag, " mem33_kept"}, int'(mem[33]), int'(old33));
      check({tag, " mem34_kept"}, int'(mem[34]), int'(old34));
      check({tag, " mem35_kept"}, int'(mem[35]), int'(old35));
    end else begin
      check({tag, " ack_cycle"}, ack_cyc, 37);
      check({tag, " ack_pulses"}, pulses, 1);
      check({tag, " ctb"}, int'(mem[33]), ectb);
      check({tag, " cto"}, int'(mem[34]), ecto);
      check({tag, " cts"}, int'(mem[35]), ects);
    end
    $display("run %s: ack_cycle=%0d pulses=%0d ctb=%0d cto=%0d cts=%0d", tag, ack_cyc, pulses,
             mem[33], mem[34], mem[35]);
  endtask

  task automatic fill(input logic [7:0] msg, input logic [7:0] pat);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < 32; i++) img[i] = msg;
    img[32] = pat;
    img[33] = 8'h11; img[34] = 8'h22; img[35] = 8'h33;
  endtask

  initial begin
    int e0, e1, e2;
    reset = 1'b1;
    start = 1'b0;
    load_req = 1'b0;
    fill(8'h00, 8'h00);
    do_load();
    repeat (2) @(posedge clk);
    #1;
    check("rst ack", int'(ack), 0);
    check("rst wr_en", int'(mem_wr_en), 0);
    check("rst addr", int'(mem_addr), 0);
    check("rst wr_data", int'(mem_wr_data), 0);
    reset = 1'b0;

    // Directed cases, with hand-derived expectations as well as the model.
    fill(8'h00, 8'h00); do_load(); run("zeros_p0", 0, 0);
    check("zeros_p0 hand", int'({mem[33], mem[34], mem[35]}), int'({8'd128, 8'd32, 8'd252}));
    fill(8'h55, 8'hA8); do_load(); run("x55_p10101", 0, 0);
    check("x55 hand", int'({mem[33], mem[34], mem[35]}), int'({8'd64, 8'd32, 8'd126}));
    fill(8'h00, 8'hF8); do_load(); run("zeros_p11111", 0, 0);
    check("nomatch hand", int'({mem[33], mem[34], mem[35]}), 0);
    fill(8'h00, 8'hF8); img[0] = 8'h0F; img[1] = 8'h80; do_load(); run("cross_only", 0, 0);
    check("cross hand", int'({mem[33], mem[34], mem[35]}), 1);

    // Random messages and patterns.
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
      // Bias some bytes toward the pattern so counts are not all tiny.
      for (int i = 0; i < 32; i += 5) img[i] = {img[32][7:3], 3'($urandom)};
      img[33] = 8'h11; img[34] = 8'h22; img[35] = 8'h33;
      do_load();
      run($sformatf("rand%0d", s), 0, 0);
    end

    // Reset mid-run: no ack, results untouched; then a fresh run completes.
    fill(8'h55, 8'hA8);
    img[33] = 8'h5A; img[34] = 8'hC3; img[35] = 8'h96;
    do_load();
    run("reset_mid", 10, 0);
    check("post_reset addr", int'(mem_addr), 0);
    run("after_reset", 0, 0);

    // Extra start during SCAN is ignored; single ack at 37.
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    img[33] = 8'h00; img[34] = 8'h00; img[35] = 8'h00;
    do_load();
    run("busy_start", 0, 5);
    ref_counts(e0, e1, e2);
    run("fresh_start", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
